// File: rtl/nonce_return_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nonce_return_arbiter: round-robin return of slave nonces to the uplink TX. |
// | Optional macro DROP_COUNT_EN enables the saturating overwrite counter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nonce_return_arbiter #(
    parameter int NUM_SLAVES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [32*NUM_SLAVES-1:0] nonce_in,
    input  logic [NUM_SLAVES-1:0]    nonce_valid,
    input  logic                     tx_busy,
    output logic [31:0]              tx_word,
    output logic                     tx_load,
    output logic [NUM_SLAVES-1:0]    pending,
    output logic [2:0]               last_slave,
    output logic [15:0]              dropped
);
    localparam logic [2:0] c_last_idx = 3'(NUM_SLAVES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GUARD = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              rr_ptr_q, rr_ptr_d;
    logic [31:0]             tx_word_q, tx_word_d;
    logic                    tx_load_q, tx_load_d;
    logic [NUM_SLAVES-1:0]   pending_q, pending_d;
    logic [2:0]              last_slave_q, last_slave_d;
    logic [31:0]             hold_q [NUM_SLAVES];
    logic [31:0]             hold_d [NUM_SLAVES];

    logic [7:0]              w_pend8;
    logic                    w_grant_found;
    logic [2:0]              w_grant_idx;
    logic [31:0]             w_hold_sel;
    logic                    w_grant;

    assign w_pend8 = 8'(pending_q);

    // Walk forward from the slot after the last grant, wrapping at NUM_SLAVES.
    always_comb begin
        logic [2:0] idx;
        idx           = rr_ptr_q;
        w_grant_found = 1'b0;
        w_grant_idx   = 3'd0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            idx = (idx == c_last_idx) ? 3'd0 : idx + 3'd1;
            if (!w_grant_found && w_pend8[idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = idx;
            end
        end
    end

    always_comb begin
        w_hold_sel = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_grant_idx == 3'(i)) begin
                w_hold_sel = hold_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        tx_word_d    = tx_word_q;
        tx_load_d    = 1'b0;
        last_slave_d = last_slave_q;
        pending_d    = pending_q;
        hold_d       = hold_q;
        w_grant      = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_grant_found && !tx_busy) begin
                    w_grant      = 1'b1;
                    tx_word_d    = w_hold_sel;
                    tx_load_d    = 1'b1;
                    last_slave_d = w_grant_idx;
                    rr_ptr_d     = w_grant_idx;
                    state_d      = LOAD;
                end
            end
            LOAD:    state_d = GUARD;
            // Busy from the transmitter is only guaranteed one cycle after the load.
            GUARD:   state_d = DRAIN;
            DRAIN:   if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A same-cycle arrival wins over the grant's clear of its slot.
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_grant && (w_grant_idx == 3'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (nonce_valid[i]) begin
                hold_d[i]    = nonce_in[32*i +: 32];
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= c_last_idx;
            tx_word_q    <= 32'd0;
            tx_load_q    <= 1'b0;
            pending_q    <= '0;
            last_slave_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            tx_word_q    <= tx_word_d;
            tx_load_q    <= tx_load_d;
            pending_q    <= pending_d;
            last_slave_q <= last_slave_d;
        end
    end

`ifdef DROP_COUNT_EN
    logic [15:0] dropped_q, dropped_d;

    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, dropped_q};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (nonce_valid[i] && pending_q[i] && !(w_grant && (w_grant_idx == 3'(i)))) begin
                sum = sum + 17'd1;
            end
        end
        dropped_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_q <= 16'd0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped = dropped_q;
`else
    assign dropped = 16'd0;
`endif

    assign tx_word    = tx_word_q;
    assign tx_load    = tx_load_q;
    assign pending    = pending_q;
    assign last_slave = last_slave_q;

endmodule
`default_nettype wire

// File: doc/nonce_return_arbiter.md
# nonce_return_arbiter

Collects found nonces from up to eight downstream serial slave receivers and feeds them, one at a time, into the single upstream serial word transmitter of the DE2-115 cluster hub. Each slave channel has a one-deep holding register. A round-robin scheduler grants the shared transmitter to pending channels and paces every load against the transmitter's busy flag. It sits between the per-slave receive buffers and the hub's uplink transmitter.

## Interface
- NUM_SLAVES, 4, number of slave channels; legal range 1..8.
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- nonce_in  in  32*NUM_SLAVES  flattened nonces; slave i occupies bits [32*i+31:32*i].
- nonce_valid  in  NUM_SLAVES  one-cycle pulse per slave; its nonce is valid in the same cycle.
- tx_busy  in  1  transmitter busy; guaranteed high by the cycle after tx_load and until the word is fully shifted out.
- tx_word  out  32  word to transmit; stable from tx_load until the next load.
- tx_load  out  1  one-cycle load strobe to the transmitter.
- pending  out  NUM_SLAVES  holding-register occupancy flags.
- last_slave  out  3  index of the most recently granted slave.
- dropped  out  16  count of overwritten, unsent nonces.

## Operation
- Reset values: tx_word=0, tx_load=0, pending=0, last_slave=0, dropped=0, state=IDLE, rr_ptr=NUM_SLAVES-1.
- Capture, per slave i:
  - On nonce_valid[i], hold[i] <= nonce slice and pending[i] <= 1.
  - If pending[i] was already 1 and the slot is not being granted this cycle, the new nonce overwrites the old one and counts as a drop.
- Grant:
  - Round-robin search starts at index rr_ptr+1 mod NUM_SLAVES and selects the first pending slave.
  - On grant, rr_ptr <= granted index.
- State machine:
  - IDLE: if any pending[i]=1 and tx_busy=0, then grant slave g, tx_word <= hold[g], tx_load <= 1, last_slave <= g, clear pending[g], and go to LOAD. Otherwise stay in IDLE.
  - LOAD: tx_load <= 0; go to GUARD. This state exists because busy is not yet visible.
  - GUARD: go to DRAIN unconditionally.
  - DRAIN: stay while tx_busy=1; go to IDLE when tx_busy=0.
- Simultaneous grant and arrival for the same slave: the pending clear loses to the set. The new nonce is held, pending stays 1, and no drop is counted, because the old value was granted.
- Simultaneous arrivals on several slaves are all captured in the same cycle.
- No pending input is accepted while tx_busy=1 in IDLE; the block waits.
- Reset mid-transfer:
  - All pending nonces are discarded and tx_load is forced to 0.
  - The transmitter is not aborted; the first load after reset still waits for tx_busy=0.

## Timing
- nonce_valid[i] high in cycle t gives pending[i]=1 in cycle t+1. With the block in IDLE and the transmitter idle, tx_load is high in cycle t+2, with tx_word valid in the same cycle.
- tx_load is exactly one cycle wide. Consecutive loads are separated by at least 3 cycles plus the transmitter's busy time.
- The grant decision uses registered pending only; a pulse arriving in cycle t is never granted before t+2.
- Worst-case wait for a pending slave is NUM_SLAVES-1 intervening transfers.

## Configuration
- DROP_COUNT_EN defined:
  - dropped is a 16-bit counter that saturates at 16'hFFFF and increments by 1 per overwrite event.
  - If several slaves overwrite in the same cycle, it increments by the number of overwriting slaves (saturating).
- DROP_COUNT_EN undefined:
  - dropped is tied to 0 and no counter logic is generated.
  - Overwrite behaviour is unchanged.

## Test plan
- Single nonce: after reset, pulse slave 2 with 32'hDEADBEEF and hold tx_busy=0. Expect tx_load two cycles later, tx_word=32'hDEADBEEF, last_slave=2, pending=0.
- Round robin: pulse slaves 0, 1 and 3 in the same cycle, with a transmitter model that stays busy for 10 cycles per word. Expect grant order 0, 1, 3, with loads spaced ≥13 cycles.
- Busy hold-off: tx_busy forced high while slave 1 is pending. Expect no tx_load. Release busy; expect tx_load within 1 cycle.
- Overwrite: while the transmitter is busy, pulse slave 0 with 32'h11111111 and then 32'h22222222. Expect 32'h22222222 to be sent and dropped=1 (dropped=0 with DROP_COUNT_EN undefined).
- Grant/arrival collision: pulse slave 0 in the same cycle it is granted. Expect pending[0]=1 afterwards, the new nonce sent in the next transfer, and dropped unchanged.
- Reset mid-transfer: assert reset during DRAIN with slaves 1 and 2 pending. Expect pending=0, tx_load=0, last_slave=0, dropped=0 in the cycle after reset.
